alu_bist: RTL

- Synthesizable built-in self-test driver for the single-cycle CPU's combinational ALU (ports A, B, ALUFun, Sign, Z).
- It is the driving end of the ALU interface. It generates pseudo-random operand pairs and sweeps all 16 supported ALUFun codes per pair.
- Every ALU result Z is compressed into a 32-bit MISR signature, which is compared against a golden value after tape-out/FPGA load.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_bist_crc32_step.sv | 11 +
 rtl/alu_bist.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU built-in self-test: ALUFun codes, sweep order,
// LFSR/MISR polynomial and FSM state encodings.
package alu_pkg;

   localparam logic [5:0] ALU_ADD   = 6'b000000;
   localparam logic [5:0] ALU_SUB   = 6'b000001;
   localparam logic [5:0] ALU_AND   = 6'b011000;
   localparam logic [5:0] ALU_OR    = 6'b011110;
   localparam logic [5:0] ALU_XOR   = 6'b010110;
   localparam logic [5:0] ALU_NOR   = 6'b010001;
   localparam logic [5:0] ALU_PASSA = 6'b011010;
   localparam logic [5:0] ALU_SLL   = 6'b100000;
   localparam logic [5:0] ALU_SRL   = 6'b100001;
   localparam logic [5:0] ALU_SRA   = 6'b100011;
   localparam logic [5:0] ALU_EQ    = 6'b110011;
   localparam logic [5:0] ALU_NEQ   = 6'b110001;
   localparam logic [5:0] ALU_LT    = 6'b110101;
   localparam logic [5:0] ALU_LEZ   = 6'b111101;
   localparam logic [5:0] ALU_LTZ   = 6'b111001;
   localparam logic [5:0] ALU_GTZ   = 6'b111111;

   // Sweep order: CODE[0] is ADD, CODE[15] is GTZ (first listed = highest index).
   localparam logic [15:0][5:0] CODE = {
      ALU_GTZ, ALU_LTZ, ALU_LEZ, ALU_LT, ALU_NEQ, ALU_EQ,
      ALU_SRA, ALU_SRL, ALU_SLL,
      ALU_PASSA, ALU_NOR, ALU_XOR, ALU_OR, ALU_AND,
      ALU_SUB, ALU_ADD
   };

   localparam logic [31:0] POLY     = 32'h04C11DB7;
   localparam logic [31:0] SIG_INIT = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_bist_crc32_step.sv
// One Galois shift of a 32-bit register: y = (x << 1) ^ (x[31] ? POLY : 0).
module crc32_step #(
   parameter logic [31:0] POLY = alu_pkg::POLY
) (
   input  logic [31:0] x,
   output logic [31:0] y
);

   assign y = {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0);

endmodule

// File: rtl/alu_bist.sv
// ALU self-test driver: LFSR operand pairs, 16-code sweep per pair, and a
// 32-bit MISR that compresses every ALU result into a signature.
module alu_bist #(
   parameter logic [31:0] POLY     = alu_pkg::POLY,
   parameter logic [31:0] SIG_INIT = alu_pkg::SIG_INIT,
   parameter int          RW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [31:0]   seed,
   input  logic [RW-1:0] rounds,
   output logic [31:0]   alu_a,
   output logic [31:0]   alu_b,
   output logic [5:0]    alu_fun,
   output logic          alu_sign,
   input  logic [31:0]   alu_z,
   output logic          busy,
   output logic          done,
   output logic [31:0]   signature
);
   import alu_pkg::*;

   state_t        state_reg, state_next;
   logic [31:0]   a_reg, a_next, b_reg, b_next, sig_reg, sig_next;
   logic [5:0]    fun_reg, fun_next;
   logic          sign_reg, sign_next, busy_reg, busy_next, done_reg, done_next;
   logic [3:0]    idx_reg, idx_next;
   logic [RW-1:0] rnd_reg, rnd_next, rounds_reg, rounds_next;

   logic [31:0]   a_step, b_step, sig_step;
   logic [3:0]    idx_inc;
   logic [RW-1:0] rnd_inc;

   crc32_step #(.POLY(POLY)) u_step_a   (.x(a_reg),   .y(a_step));
   crc32_step #(.POLY(POLY)) u_step_b   (.x(b_reg),   .y(b_step));
   crc32_step #(.POLY(POLY)) u_step_sig (.x(sig_reg), .y(sig_step));

   assign idx_inc = idx_reg + 4'd1;
   assign rnd_inc = rnd_reg + RW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         fun_reg    <= '0;
         sign_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         sig_reg    <= SIG_INIT;
         idx_reg    <= '0;
         rnd_reg    <= '0;
         rounds_reg <= '0;
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         fun_reg    <= fun_next;
         sign_reg   <= sign_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         sig_reg    <= sig_next;
         idx_reg    <= idx_next;
         rnd_reg    <= rnd_next;
         rounds_reg <= rounds_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      fun_next    = fun_reg;
      sign_next   = sign_reg;
      busy_next   = busy_reg;
      done_next   = done_reg;
      sig_next    = sig_reg;
      idx_next    = idx_reg;
      rnd_next    = rnd_reg;
      rounds_next = rounds_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               // An all-zero LFSR state would lock up, so substitute 1.
               a_next      = (seed == 32'h0)  ? 32'h1 : seed;
               b_next      = (~seed == 32'h0) ? 32'h1 : ~seed;
               sig_next    = SIG_INIT;
               idx_next    = '0;
               rnd_next    = '0;
               fun_next    = CODE[0];
               sign_next   = 1'b1;
               rounds_next = rounds;
               if (rounds == '0) begin
                  state_next = DONE;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  state_next = RUN;
                  busy_next  = 1'b1;
                  done_next  = 1'b0;
               end
            end
         end
         RUN: begin
            sig_next = sig_step ^ alu_z;
            if (idx_reg != 4'd15) begin
               idx_next = idx_inc;
               fun_next = CODE[idx_inc];
            end else begin
               idx_next  = '0;
               fun_next  = CODE[0];
               a_next    = a_step;
               b_next    = b_step;
               rnd_next  = rnd_inc;
               sign_next = ~sign_reg;
               if (rnd_inc == rounds_reg) begin
                  state_next = DONE;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign alu_a     = a_reg;
   assign alu_b     = b_reg;
   assign alu_fun   = fun_reg;
   assign alu_sign  = sign_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign signature = sig_reg;

endmodule
